// File: rtl/ysyx_24100029_bpu_if.sv
// ysyx_24100029 BPU bundle: IFU lookup/prediction plus branch resolution reports.
// The master side belongs to the IFU/pipeline control, the slave side to the BPU.
interface ysyx_24100029_bpu_if;
    logic        lookup_valid;
    logic [31:0] lookup_pc;
    logic        pred_valid;
    logic        pred_res;
    logic [31:0] pred_pc;
    logic        br_valid;
    logic        br_is_taken;
    logic [31:0] br_pc;
    logic [1:0]  br_pc_type;
    logic [31:0] br_npc;

    modport master (
        output lookup_valid,
        output lookup_pc,
        input  pred_valid,
        input  pred_res,
        input  pred_pc,
        output br_valid,
        output br_is_taken,
        output br_pc,
        output br_pc_type,
        output br_npc
    );

    modport slave (
        input  lookup_valid,
        input  lookup_pc,
        output pred_valid,
        output pred_res,
        output pred_pc,
        input  br_valid,
        input  br_is_taken,
        input  br_pc,
        input  br_pc_type,
        input  br_npc
    );
endinterface

// File: rtl/ysyx_24100029_bpu.sv
// ysyx_24100029 branch prediction unit: direct-mapped BTB with 2-bit
// saturating counters, one registered lookup per cycle, trained by br_* reports.
module ysyx_24100029_bpu #(
    parameter int ENTRIES = 16
) (
    input logic                clk,
    input logic                rst,
    ysyx_24100029_bpu_if.slave bus
);
    localparam int IDX_W = $clog2(ENTRIES);
    localparam int TAG_W = 30 - IDX_W;

    typedef logic [IDX_W-1:0] idx_t;
    typedef logic [TAG_W-1:0] tag_t;

    logic        v_q   [ENTRIES];
    tag_t        tag_q [ENTRIES];
    logic [31:0] tgt_q [ENTRIES];
    logic [1:0]  cnt_q [ENTRIES];

    logic        pred_valid_q;
    logic        pred_res_q;
    logic [31:0] pred_pc_q;

    // Lookup side: reads array state from before the edge, no bypass.
    idx_t        l_idx;
    tag_t        l_tag;
    logic        l_hit;
    logic        l_res;
    logic [31:0] l_seq;
    logic [31:0] l_npc;

    assign l_idx = bus.lookup_pc[IDX_W+1:2];
    assign l_tag = bus.lookup_pc[31:IDX_W+2];
    assign l_hit = v_q[l_idx] && (tag_q[l_idx] == l_tag);
    assign l_res = bus.lookup_valid && l_hit && cnt_q[l_idx][1];
    assign l_seq = bus.lookup_pc + 32'd4;
    assign l_npc = l_res ? tgt_q[l_idx] : l_seq;

    // Update side
    idx_t        u_idx;
    tag_t        u_tag;
    logic        u_hit;
    logic        u_uncond;
    logic [1:0]  u_old;
    logic [1:0]  u_cnt;
    logic        u_we;
    logic        u_alloc;
    logic        u_tgt_we;

    assign u_idx    = bus.br_pc[IDX_W+1:2];
    assign u_tag    = bus.br_pc[31:IDX_W+2];
    assign u_hit    = v_q[u_idx] && (tag_q[u_idx] == u_tag);
    assign u_uncond = (bus.br_pc_type == 2'b01);
    assign u_old    = cnt_q[u_idx];

    always_comb begin
        u_we     = 1'b0;
        u_alloc  = 1'b0;
        u_tgt_we = 1'b0;
        u_cnt    = u_old;
        if (bus.br_valid) begin
            if (u_hit) begin
                u_we = 1'b1;
                if (u_uncond) begin
                    u_cnt    = 2'b11;
                    u_tgt_we = 1'b1;
                end else if (bus.br_is_taken) begin
                    u_cnt    = (u_old == 2'b11) ? 2'b11 : u_old + 2'd1;
                    u_tgt_we = 1'b1;
                end else begin
                    u_cnt = (u_old == 2'b00) ? 2'b00 : u_old - 2'd1;
                end
            end else if (bus.br_is_taken) begin
                u_we     = 1'b1;
                u_alloc  = 1'b1;
                u_tgt_we = 1'b1;
                u_cnt    = u_uncond ? 2'b11 : 2'b10;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < ENTRIES; i++) begin
                v_q[i]   <= 1'b0;
                cnt_q[i] <= 2'b01;
            end
        end else if (u_we) begin
            cnt_q[u_idx] <= u_cnt;
            if (u_alloc) begin
                v_q[u_idx] <= 1'b1;
            end
        end
    end

    // Tag and target carry no reset; v guards them.
    always_ff @(posedge clk) begin
        if (!rst && u_alloc) begin
            tag_q[u_idx] <= u_tag;
        end
        if (!rst && u_tgt_we) begin
            tgt_q[u_idx] <= bus.br_npc;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pred_valid_q <= 1'b0;
            pred_res_q   <= 1'b0;
            pred_pc_q    <= 32'd0;
        end else begin
            pred_valid_q <= bus.lookup_valid;
            pred_res_q   <= l_res;
            pred_pc_q    <= l_npc;
        end
    end

    assign bus.pred_valid = pred_valid_q;
    assign bus.pred_res   = pred_res_q;
    assign bus.pred_pc    = pred_pc_q;

    logic unused_bits;
    assign unused_bits = ^{bus.lookup_pc[1:0], bus.br_pc[1:0]};
endmodule

// File: tb/tb_ysyx_24100029_bpu.sv
// Bench for ysyx_24100029_bpu: directed vectors with literal pins
// plus a cycle-by-cycle comparison against a behavioural BTB model.
module tb_ysyx_24100029_bpu;
    localparam int ENTRIES = 16;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    ysyx_24100029_bpu_if bif ();

    ysyx_24100029_bpu #(.ENTRIES(ENTRIES)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bif)
    );

    int n_cmp = 0;
    int n_bad = 0;

    // Behavioural model: plain arrays indexed by word address modulo ENTRIES.
    bit          mv   [ENTRIES];
    logic [31:0] mtag [ENTRIES];
    logic [31:0] mtgt [ENTRIES];
    int          mc   [ENTRIES];
    logic        e_v, e_r;
    logic [31:0] e_pc;
    bit          armed = 0;

    function automatic int slot(input logic [31:0] pc);
        return int'((pc >> 2) % ENTRIES);
    endfunction

    function automatic logic [31:0] tagof(input logic [31:0] pc);
        return pc / (4 * ENTRIES);
    endfunction

    always @(posedge clk) begin
        int  li, ui;
        bit  lh, uh;
        armed = 1;
        if (rst) begin
            e_v  = 0;
            e_r  = 0;
            e_pc = 32'd0;
            for (int i = 0; i < ENTRIES; i++) begin
                mv[i] = 0;
                mc[i] = 1;
            end
        end else begin
            li   = slot(bif.lookup_pc);
            lh   = mv[li] && (mtag[li] == tagof(bif.lookup_pc));
            e_v  = bif.lookup_valid;
            e_r  = bif.lookup_valid && lh && (mc[li] >= 2);
            e_pc = e_r ? mtgt[li] : bif.lookup_pc + 32'd4;
            if (bif.br_valid) begin
                ui = slot(bif.br_pc);
                uh = mv[ui] && (mtag[ui] == tagof(bif.br_pc));
                if (uh) begin
                    if (bif.br_pc_type == 2'b01) begin
                        mc[ui]   = 3;
                        mtgt[ui] = bif.br_npc;
                    end else if (bif.br_is_taken) begin
                        mc[ui]   = (mc[ui] + 1 > 3) ? 3 : mc[ui] + 1;
                        mtgt[ui] = bif.br_npc;
                    end else begin
                        mc[ui] = (mc[ui] - 1 < 0) ? 0 : mc[ui] - 1;
                    end
                end else if (bif.br_is_taken) begin
                    mv[ui]   = 1;
                    mtag[ui] = tagof(bif.br_pc);
                    mtgt[ui] = bif.br_npc;
                    mc[ui]   = (bif.br_pc_type == 2'b01) ? 3 : 2;
                end
            end
        end
    end

    string       lit_name;
    bit          lit_on = 0;
    logic        lit_v, lit_r;
    logic [31:0] lit_pc;

    always @(negedge clk) begin
        if (armed) begin
            n_cmp++;
            if ({bif.pred_valid, bif.pred_res, bif.pred_pc} !== {e_v, e_r, e_pc}) begin
                n_bad++;
                $display("FAIL model t=%0t got v=%b r=%b pc=%h want v=%b r=%b pc=%h",
                         $time, bif.pred_valid, bif.pred_res, bif.pred_pc, e_v, e_r, e_pc);
            end
        end
        if (lit_on) begin
            lit_on = 0;
            n_cmp++;
            if ({bif.pred_valid, bif.pred_res, bif.pred_pc} !== {lit_v, lit_r, lit_pc}) begin
                n_bad++;
                $display("FAIL %s got v=%b r=%b pc=%h want v=%b r=%b pc=%h", lit_name,
                         bif.pred_valid, bif.pred_res, bif.pred_pc, lit_v, lit_r, lit_pc);
            end
            n_cmp++;
            if ({e_v, e_r, e_pc} !== {lit_v, lit_r, lit_pc}) begin
                n_bad++;
                $display("FAIL pin_%s model v=%b r=%b pc=%h want v=%b r=%b pc=%h", lit_name,
                         e_v, e_r, e_pc, lit_v, lit_r, lit_pc);
            end
        end
    end

    task automatic drive(input logic r, input logic lv, input logic [31:0] lpc,
                         input logic bv, input logic bt, input logic [31:0] bpc,
                         input logic [1:0] bty, input logic [31:0] bnpc);
        rst              = r;
        bif.lookup_valid = lv;
        bif.lookup_pc    = lpc;
        bif.br_valid     = bv;
        bif.br_is_taken  = bt;
        bif.br_pc        = bpc;
        bif.br_pc_type   = bty;
        bif.br_npc       = bnpc;
        @(posedge clk);
        #2;
    endtask

    task automatic look(input logic [31:0] pc);
        drive(1'b0, 1'b1, pc, 1'b0, 1'b0, 32'd0, 2'b00, 32'd0);
    endtask

    task automatic upd(input logic [31:0] pc, input logic t, input logic [1:0] ty,
                       input logic [31:0] npc);
        drive(1'b0, 1'b0, 32'd0, 1'b1, t, pc, ty, npc);
    endtask

    task automatic expect_lit(input string nm, input logic v, input logic r,
                              input logic [31:0] pc);
        lit_name = nm;
        lit_v    = v;
        lit_r    = r;
        lit_pc   = pc;
        lit_on   = 1;
    endtask

    initial begin
        drive(1'b1, 1'b0, 32'd0, 1'b0, 1'b0, 32'd0, 2'b00, 32'd0);
        drive(1'b1, 1'b1, 32'h1000, 1'b1, 1'b1, 32'h80000010, 2'b00, 32'h4);
        expect_lit("reset", 1'b0, 1'b0, 32'd0);

        look(32'h80000000);
        expect_lit("cold_miss", 1'b1, 1'b0, 32'h80000004);

        upd(32'h80000010, 1'b1, 2'b00, 32'h80000100);
        look(32'h80000010);
        expect_lit("alloc_hit", 1'b1, 1'b1, 32'h80000100);

        upd(32'h80000010, 1'b0, 2'b00, 32'h0);
        look(32'h80000010);
        expect_lit("hyst_nt", 1'b1, 1'b0, 32'h80000014);
        upd(32'h80000010, 1'b1, 2'b00, 32'h80000100);
        upd(32'h80000010, 1'b1, 2'b00, 32'h80000100);
        upd(32'h80000010, 1'b0, 2'b00, 32'h0);
        look(32'h80000010);
        expect_lit("hyst_t", 1'b1, 1'b1, 32'h80000100);

        repeat (3) upd(32'h80000010, 1'b1, 2'b00, 32'h80000100);
        upd(32'h80000010, 1'b0, 2'b00, 32'h0);
        look(32'h80000010);
        expect_lit("sat_top", 1'b1, 1'b1, 32'h80000100);
        repeat (4) upd(32'h80000010, 1'b0, 2'b00, 32'h0);
        upd(32'h80000010, 1'b1, 2'b00, 32'h80000100);
        look(32'h80000010);
        expect_lit("sat_bot", 1'b1, 1'b0, 32'h80000014);

        upd(32'h80000010, 1'b1, 2'b00, 32'h80000100);
        upd(32'h80000050, 1'b1, 2'b00, 32'h80000200);
        look(32'h80000010);
        expect_lit("alias_miss", 1'b1, 1'b0, 32'h80000014);
        look(32'h80000050);
        expect_lit("alias_new", 1'b1, 1'b1, 32'h80000200);

        drive(1'b0, 1'b1, 32'h80000020, 1'b1, 1'b1, 32'h80000020, 2'b00, 32'h80000300);
        expect_lit("same_cycle", 1'b1, 1'b0, 32'h80000024);
        look(32'h80000020);
        expect_lit("next_cycle", 1'b1, 1'b1, 32'h80000300);

        upd(32'h80000030, 1'b1, 2'b01, 32'h80000400);
        upd(32'h80000030, 1'b0, 2'b00, 32'h0);
        look(32'h80000030);
        expect_lit("uncond", 1'b1, 1'b1, 32'h80000400);

        look(32'hFFFFFFFC);
        expect_lit("wrap", 1'b1, 1'b0, 32'h00000000);
        drive(1'b0, 1'b0, 32'h1000, 1'b0, 1'b0, 32'd0, 2'b00, 32'd0);
        expect_lit("no_lookup", 1'b0, 1'b0, 32'h1004);

        drive(1'b1, 1'b1, 32'h80000020, 1'b1, 1'b1, 32'h80000040, 2'b00, 32'h80000500);
        expect_lit("mid_reset", 1'b0, 1'b0, 32'd0);
        look(32'h80000020);
        expect_lit("post_rst_a", 1'b1, 1'b0, 32'h80000024);
        look(32'h80000030);
        expect_lit("post_rst_b", 1'b1, 1'b0, 32'h80000034);
        look(32'h80000050);
        expect_lit("post_rst_c", 1'b1, 1'b0, 32'h80000054);
        look(32'h80000040);
        expect_lit("post_rst_d", 1'b1, 1'b0, 32'h80000044);

        for (int k = 0; k < 400; k++) begin
            drive(($urandom_range(0, 59) == 0),
                  1'($urandom_range(0, 3) != 0),
                  32'h80000000 + 32'($urandom_range(0, 39)) * 4,
                  1'($urandom_range(0, 1)),
                  1'($urandom_range(0, 2) != 0),
                  32'h80000000 + 32'($urandom_range(0, 39)) * 4,
                  2'($urandom_range(0, 3)),
                  32'($urandom));
        end
        drive(1'b0, 1'b0, 32'd0, 1'b0, 1'b0, 32'd0, 2'b00, 32'd0);
        @(negedge clk);
        #1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
